// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams instruction words into the cell-organised
// instruction memory, MSB cell first at ascending addresses.
// Optional build macro LOADER_CHECKSUM_EN adds a running word checksum port.
module instr_mem_loader #(
  parameter int WORD_LEN = 16,
  parameter int CELL_W   = 4,
  parameter int MEM_SIZE = 32,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(MEM_SIZE)-1:0] base_addr,
  input  logic [CNT_W-1:0]            word_count,
  input  logic                        in_valid,
  input  logic [WORD_LEN-1:0]         in_data,
  output logic                        in_ready,
  output logic                        mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [CELL_W-1:0]           mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_LEN-1:0]         checksum
`endif
);

  localparam int AW  = $clog2(MEM_SIZE);
  localparam int CPW = WORD_LEN / CELL_W;
  localparam int CIW = (CPW > 1) ? $clog2(CPW) : 1;
  localparam logic [CIW-1:0] LAST_CELL = CIW'(CPW - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t              state, state_n;
  logic [AW:0]         ptr, ptr_n, ptr_inc;  // top bit = overflow, kept sticky
  logic [CNT_W-1:0]    rem, rem_n;
  logic [WORD_LEN-1:0] word, word_n;         // left-aligned cells still to write
  logic [WORD_LEN-1:0] src;
  logic [CIW-1:0]      idx, idx_n;           // cell index currently on mem_*
  logic                mem_we_n, done_n, err_n;
  logic [AW-1:0]       mem_addr_n;
  logic [CELL_W-1:0]   mem_wdata_n;
  logic                hs, issue;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_LEN-1:0] sum_n;
`endif

  assign in_ready = (state == ACCEPT);
  assign busy     = (state != IDLE);
  assign hs       = in_ready && in_valid;
  // A cell is launched at the handshake edge and at every WRITE edge but the last,
  // so the registered mem_* outputs show cell i during the i-th WRITE cycle.
  assign issue    = hs || (state == WRITE && idx != LAST_CELL);
  assign src      = hs ? in_data : word;
  assign ptr_inc  = ptr + 1'b1;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    rem_n       = rem;
    word_n      = word;
    idx_n       = idx;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done_n      = 1'b0;
    err_n       = err;
`ifdef LOADER_CHECKSUM_EN
    sum_n       = checksum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          err_n = 1'b0;
          ptr_n = {1'b0, base_addr};
          rem_n = word_count;
`ifdef LOADER_CHECKSUM_EN
          sum_n = '0;
`endif
          if (word_count == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          state_n = WRITE;
          idx_n   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_n   = checksum + in_data;
`endif
        end
      end
      WRITE: begin
        if (idx == LAST_CELL) begin
          rem_n = rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ACCEPT;
          end
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Overflowed cells still consume an address but are never written.
    if (issue) begin
      mem_wdata_n = src[WORD_LEN-1 -: CELL_W];
      word_n      = src << CELL_W;
      mem_addr_n  = ptr[AW-1:0];
      mem_we_n    = ~ptr[AW];
      err_n       = err | ptr[AW];
      ptr_n       = {ptr[AW] | ptr_inc[AW], ptr_inc[AW-1:0]};
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      word      <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      rem       <= rem_n;
      word      <= word_n;
      idx       <= idx_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      done      <= done_n;
      err       <= err_n;
`ifdef LOADER_CHECKSUM_EN
      checksum  <= sum_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and random loads checked every cycle against
// a schedule-level model (which cell lands at which address on which cycle).
module tb_instr_mem_loader;
  localparam int WORD_LEN = 16, CELL_W = 4, MEM_SIZE = 32, CNT_W = 8;
  localparam int AW = 5, CPW = 4;
  localparam longint BIG = 64'h7fff_ffff_ffff;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic [WORD_LEN-1:0] in_data = '0;
  logic in_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [CELL_W-1:0] mem_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_LEN-1:0] checksum;
`endif

  instr_mem_loader #(.WORD_LEN(WORD_LEN), .CELL_W(CELL_W), .MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  longint cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: each accepted word becomes CPW scheduled cells at known cycles.
  typedef struct { longint c; int addr; logic [CELL_W-1:0] data; bit we; } cell_t;
  cell_t q[$];
  bit m_act = 0, m_err = 0;
  longint m_done_cyc = BIG, m_ready_from = BIG;
  int m_rem = 0, m_ptr = 0;
  logic [WORD_LEN-1:0] m_sum = '0;

  // Observation logs for the directed literal checks.
  logic [AW+CELL_W-1:0] wlog[$];
  longint last_we_cyc = 0, first_we_cyc = 0, hs_cyc = 0, done_cyc_log = 0, start_cyc_log = 0;
  int n_done = 0;
  bit ready_seen = 0;
  logic [WORD_LEN-1:0] src[$];

  always @(negedge clk) begin : cmp
    bit busy_e, ready_e, done_e, has;
    cell_t e;
    busy_e  = m_act && cyc <= m_done_cyc;
    ready_e = m_act && m_rem > 0 && cyc >= m_ready_from;
    done_e  = m_act && cyc == m_done_cyc;
    has     = q.size() > 0 && q[0].c == cyc;
    if (has) begin
      e = q.pop_front();
      if (!e.we) m_err = 1;
    end
    if (chk_en) begin
      check("busy", busy, busy_e);
      check("in_ready", in_ready, ready_e);
      check("mem_we", mem_we, has && e.we);
      if (has && e.we) begin
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.data);
      end
      check("done", done, done_e);
      check("err", err, m_err);
`ifdef LOADER_CHECKSUM_EN
      if (done_e) check("checksum", checksum, m_sum);
`endif
    end
    if (mem_we) begin
      if (wlog.size() == 0) first_we_cyc = cyc;
      wlog.push_back({mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (done) begin n_done++; done_cyc_log = cyc; end
    if (start && !busy) start_cyc_log = cyc;
    if (in_ready) ready_seen = 1;
    if (in_valid && in_ready) hs_cyc = cyc;
    if (rst) begin
      m_act = 0; q.delete(); m_err = 0; m_sum = '0; m_rem = 0;
    end else begin
      if (!busy_e && start) begin
        m_act = 1; m_err = 0; m_sum = '0;
        m_rem = int'(word_count); m_ptr = int'(base_addr);
        if (word_count == 0) m_done_cyc = cyc + 1;
        else begin m_done_cyc = BIG; m_ready_from = cyc + 1; end
      end else if (ready_e && in_valid) begin
        for (int j = 0; j < CPW; j++) begin
          e.c    = cyc + 1 + j;
          e.addr = m_ptr + j;
          e.data = CELL_W'(in_data >> ((CPW - 1 - j) * CELL_W));
          e.we   = (m_ptr + j) < MEM_SIZE;
          q.push_back(e);
        end
        m_ptr += CPW; m_sum += in_data; m_rem--;
        if (m_rem == 0) m_done_cyc = cyc + CPW + 1;
        else m_ready_from = cyc + CPW + 1;
      end
      if (m_act && cyc >= m_done_cyc) m_act = 0;
    end
    cyc++;
  end

  task automatic clear_logs();
    wlog.delete(); n_done = 0; ready_seen = 0;
  endtask

  // Starts a load and feeds src[] until done; called at posedge+1.
  task automatic run_load(input int base, input int cnt, input int stall, input bit rnd,
                          input int stray_k, input bit rnd_stray, input bit allow_rst,
                          output bit aborted);
    int idx = 0, hold = 0;
    bit got = 0;
    aborted = 0;
    base_addr = AW'(base); word_count = CNT_W'(cnt); start = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 1000 && !got && !aborted; k++) begin
      start = 0;
      if (k == stray_k || (rnd_stray && busy && $urandom_range(0, 7) == 0)) begin
        start = 1; base_addr = AW'($urandom); word_count = CNT_W'($urandom_range(0, 9));
      end
      if (hold > 0) begin in_valid = 0; hold--; end
      else in_valid = (idx < src.size()) && (!rnd || $urandom_range(0, 2) != 0);
      in_data = in_valid ? src[idx] : 16'($urandom);
      if (allow_rst && $urandom_range(0, 199) == 0) rst = 1;
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; hold = stall; end
      if (done) got = 1;
      if (rst) aborted = 1;
      @(posedge clk); #1;
      rst = 0;
    end
    start = 0; in_valid = 0;
    if (!aborted) check("load_done_seen", got, 1);
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ab;
    logic [3:0] t2c [12];
    t2c = '{4'h3, 4'h7, 4'h0, 4'h5, 4'h4, 4'h3, 4'h7, 4'h0, 4'h6, 4'h7, 4'h0, 4'h4};
    repeat (3) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;

    // Single word
    clear_logs(); src = '{16'h3304};
    run_load(8, 1, 0, 0, -1, 0, 0, ab);
    check("t1_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t1_w0", wlog[0], {5'd8, 4'h3});
      check("t1_w1", wlog[1], {5'd9, 4'h3});
      check("t1_w2", wlog[2], {5'd10, 4'h0});
      check("t1_w3", wlog[3], {5'd11, 4'h4});
    end
    check("t1_first_lat", 32'(first_we_cyc - hs_cyc), 1);
    check("t1_done_lat", 32'(done_cyc_log - last_we_cyc), 1);
    check("t1_err", err, 0);

    // Three words with input stalls
    clear_logs(); src = '{16'h3705, 16'h4370, 16'h6704};
    run_load(12, 3, CPW + 2, 0, -1, 0, 0, ab);
    check("t2_nwrites", wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++)
      check("t2_cell", wlog[i], {5'(12 + i), t2c[i]});
    check("t2_ndone", n_done, 1);
`ifdef LOADER_CHECKSUM_EN
    check("t2_checksum", checksum, 16'hE179);
`endif

    // Overflow past the top of memory
    clear_logs(); src = '{16'hABCD};
    run_load(30, 1, 0, 0, -1, 0, 0, ab);
    check("t3_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t3_w0", wlog[0], {5'd30, 4'hA});
      check("t3_w1", wlog[1], {5'd31, 4'hB});
    end
    check("t3_err", err, 1);
    repeat (3) @(posedge clk); #1;
    check("t3_err_sticky", err, 1);

    // Zero count
    clear_logs(); src.delete();
    run_load(0, 0, 0, 0, -1, 0, 0, ab);
    check("t4_nwrites", wlog.size(), 0);
    check("t4_ready_seen", ready_seen, 0);
    check("t4_done_lat", 32'(done_cyc_log - start_cyc_log), 1);
    check("t4_err_cleared", err, 0);

    // Reset during the second cell of the first word
    clear_logs();
    base_addr = 0; word_count = 2; start = 1;
    @(posedge clk); #1 start = 0; in_valid = 1; in_data = 16'h1234;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t5_mem_we", mem_we, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_nwrites", wlog.size(), 2);
    clear_logs(); src = '{16'hBEEF};
    run_load(16, 1, 0, 0, -1, 0, 0, ab);
    check("t5_reload_n", wlog.size(), 4);
    if (wlog.size() == 4) check("t5_reload_w0", wlog[0], {5'd16, 4'hB});

    // Start while busy is ignored
    clear_logs(); src = '{16'h1111, 16'h2222};
    run_load(4, 2, 0, 0, 2, 0, 0, ab);
    check("t6_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check("t6_addr", wlog[i][AW+CELL_W-1:CELL_W], 4 + i);
    check("t6_ndone", n_done, 1);

    // Random loads, stray starts and occasional reset
    for (int n = 0; n < 40; n++) begin
      int cnt;
      cnt = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
      src.delete();
      for (int w = 0; w < cnt; w++) src.push_back(16'($urandom));
      run_load($urandom_range(0, MEM_SIZE - 1), cnt, 0, 1, -1, 1, 1, ab);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk); #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction memory read port. It loads program words into the cell-organised instruction memory at run time, replacing the hard-coded reset preload.
- It accepts whole instruction words over a valid/ready stream and splits each word into cells. Cells are written MSB-cell first to ascending addresses, the same order in which the fetch side reassembles them.
- It sits between the testbench/host boot interface and the instruction memory write port. The host holds the core in reset while busy=1.

Parameters:
- WORD_LEN, 16: instruction word width in bits.
- CELL_W, 4: memory cell width in bits. WORD_LEN must be an integer multiple of CELL_W.
- MEM_SIZE, 32: number of cells in the instruction memory. Must be a power of 2.
- CNT_W, 8: width of the word_count input.

Ports:
- clk, in, 1: clock. All logic is rising-edge.
- rst, in, 1: reset. Synchronous, active-high.
- start, in, 1: single-cycle request to begin a load. Sampled only in IDLE.
- base_addr, in, $clog2(MEM_SIZE): first cell address. Latched on start.
- word_count, in, CNT_W: number of words to load. Latched on start.
- in_valid, in, 1: input word valid.
- in_data, in, WORD_LEN: input instruction word.
- in_ready, out, 1: loader can accept a word.
- mem_we, out, 1: cell write enable.
- mem_addr, out, $clog2(MEM_SIZE): cell address.
- mem_wdata, out, CELL_W: cell data.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: single-cycle pulse at the end of a load.
- err, out, 1: sticky address-overflow flag. Cleared on start.

Behaviour:
- Definitions: CPW = WORD_LEN/CELL_W (cells per word). ptr is an internal address of width $clog2(MEM_SIZE)+1, so overflow is visible.
- Reset: state=IDLE. in_ready, mem_we, busy, done and err are all 0. mem_addr and mem_wdata are 0.
- Outputs are registered; mem_* and done are driven from flops.
- IDLE:
  - start=1 with word_count>0: latch ptr=base_addr and remaining=word_count, clear err, go to ACCEPT.
  - start=1 with word_count=0: clear err, go to DONE. No writes occur.
- ACCEPT:
  - in_ready=1 combinationally from state.
  - On in_valid&in_ready: latch word=in_data, set cell index i=0, go to WRITE. in_ready drops in the following cycle.
- WRITE (one cell per cycle):
  - Drive mem_wdata = word[WORD_LEN-1-i*CELL_W -: CELL_W] and mem_addr = ptr[low bits]. Then ptr++ and i++.
  - If ptr >= MEM_SIZE at the write cycle: mem_we=0 and err is set. ptr still increments. No wrap-around write ever occurs.
  - Otherwise mem_we=1.
  - After cell CPW-1: decrement remaining. Go to DONE if remaining reaches 0, else return to ACCEPT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Latency: the first mem_we occurs 1 cycle after the handshake.
  - Throughput: 1 word per CPW+1 cycles.
  - done is asserted 1 cycle after the last cell write.
- start while busy is ignored; latched parameters are unchanged.
- in_valid outside ACCEPT is ignored; in_data need not be held.
- err persists through DONE and IDLE until the next start.
- rst mid-load: synchronously returns to IDLE with all outputs at reset values. Any partial word is abandoned and no further cells are written.
- Byte order: the cell at the lowest address is the most-significant CELL_W bits of the word, so a fetch at base_addr returns the loaded word unchanged.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - Extra output port checksum, WORD_LEN bits.
  - Holds a running modulo-2^WORD_LEN sum of all words accepted since the last start.
  - Cleared to 0 on start and on rst; updated on each in_valid&in_ready.
  - Valid when done pulses and held until the next start.
- Without the macro: the port and the adder are absent, and behaviour is otherwise identical.

Test Plan:
- Single word (start, base_addr=8, word_count=1, in_data=16'h3304) -> writes (8,3),(9,3),(10,0),(11,4) on 4 consecutive cycles. done pulses 1 cycle after the (11,4) write. err=0.
- Three words (16'h3705, 16'h4370, 16'h6704) at base 12 with in_valid stalled 2 cycles between words -> 12 writes at addresses 12..23 in MSB-cell order, none missed or duplicated. With LOADER_CHECKSUM_EN: checksum=16'hE179.
- Overflow (base=30, count=1, word 16'hABCD) -> writes (30,A),(31,B) only. mem_we=0 for the last two cells. err=1 until the next start.
- Zero count (start, word_count=0) -> no mem_we, in_ready stays 0, done pulses 1 cycle later.
- Reset mid-load: assert rst during the 2nd cell of word 1 -> the next cycle shows mem_we=0, busy=0, in_ready=0. No further writes occur, and a new start loads normally.
- Start while busy: start with base 0 asserted during WRITE -> ignored. Addresses continue from the original base and done pulses once.
